// File: rtl/xnor_seq_pkg.sv
// Shared types and helpers for the XNOR gate test sequencer.
package xnor_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef logic [1:0] vec_t;

    localparam vec_t LAST_VEC = 2'b11;

    // Response of a healthy 2-input XNOR for the applied vector {a,b}.
    function automatic logic expected_y(input vec_t v);
        return ~(v[1] ^ v[0]);
    endfunction

endpackage

// File: rtl/xnor_seq_dwell_cnt.sv
// Dwell timer: counts cycles a vector is held and flags the final one.
module xnor_seq_dwell_cnt #(
    parameter int DWELL_CYCLES = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_last
);

    localparam logic [7:0] LAST_COUNT = 8'(DWELL_CYCLES - 1);

    logic [7:0] r_count;

    // Wraps to zero after the last cycle so the next vector starts a fresh window.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= 8'd0;
        end else if (i_clear) begin
            r_count <= 8'd0;
        end else if (i_enable) begin
            if (r_count == LAST_COUNT) begin
                r_count <= 8'd0;
            end else begin
                r_count <= r_count + 8'd1;
            end
        end
    end

    assign o_last = (r_count == LAST_COUNT);

endmodule

// File: rtl/xnor_test_sequencer.sv
// Walks a 2-input XNOR through all four input vectors and counts wrong responses.
// Optional capture[3:0] output of the raw samples when XNOR_SEQ_CAPTURE_EN is defined.
module xnor_test_sequencer
    import xnor_seq_pkg::*;
#(
    parameter int DWELL_CYCLES = 4,
    parameter int ERR_W        = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             y_in,
    output logic             a_out,
    output logic             b_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_count,
    output logic [1:0]       vec_idx
`ifdef XNOR_SEQ_CAPTURE_EN
    ,
    output logic [3:0]       capture
`endif
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           r_state;
    state_t           w_next;
    vec_t             r_vec;
    logic [ERR_W-1:0] r_errCount;
    logic             r_pass;
    logic             w_accept;
    logic             w_last;
    logic             w_sample;
    logic             w_mismatch;
    logic             w_final;

    assign w_accept   = (r_state == IDLE) && start;
    assign w_sample   = (r_state == RUN) && w_last;
    assign w_mismatch = w_sample && (y_in != expected_y(r_vec));
    assign w_final    = w_sample && (r_vec == LAST_VEC);

    xnor_seq_dwell_cnt #(
        .DWELL_CYCLES(DWELL_CYCLES)
    ) u_dwell (
        .clk     (clk),
        .rst     (rst),
        .i_clear (w_accept),
        .i_enable(r_state == RUN),
        .o_last  (w_last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            IDLE:    if (start)   w_next = RUN;
            RUN:     if (w_final) w_next = DONE;
            DONE:                 w_next = IDLE;
            default:              w_next = IDLE;
        endcase
    end

    // Vector index returns to 00 after the last sample so IDLE/DONE drive zeros.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_vec <= 2'b00;
        end else if (w_accept) begin
            r_vec <= 2'b00;
        end else if (w_sample) begin
            r_vec <= w_final ? 2'b00 : r_vec + 2'b01;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_errCount <= '0;
        end else if (w_accept) begin
            r_errCount <= '0;
        end else if (w_mismatch && (r_errCount != ERR_MAX)) begin
            r_errCount <= r_errCount + 1'b1;
        end
    end

    // The final sample is not yet in r_errCount, so fold it in directly.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pass <= 1'b0;
        end else if (w_accept) begin
            r_pass <= 1'b0;
        end else if (w_final) begin
            r_pass <= (r_errCount == '0) && !w_mismatch;
        end
    end

`ifdef XNOR_SEQ_CAPTURE_EN
    logic [3:0] r_capture;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_capture <= 4'b0000;
        end else if (w_accept) begin
            r_capture <= 4'b0000;
        end else if (w_sample) begin
            r_capture[r_vec] <= y_in;
        end
    end

    assign capture = r_capture;
`endif

    assign a_out     = r_vec[1];
    assign b_out     = r_vec[0];
    assign vec_idx   = r_vec;
    assign busy      = (r_state == RUN);
    assign done      = (r_state == DONE);
    assign pass      = r_pass;
    assign err_count = r_errCount;

endmodule

// File: tb/tb_xnor_test_sequencer.sv
// Randomized self-checking bench: two sequencer instances (dwell 4 / 3-bit errors
// and dwell 1 / 2-bit errors) against a cycle-count reference model.
module tb_xnor_test_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] resp = 4'b1001;
    logic [3:0] idealTab = 4'b1001;

    logic       y1, a1, b1, busy1, done1, pass1;
    logic [2:0] err1;
    logic [1:0] vec1;
    logic       y2, a2, b2, busy2, done2, pass2;
    logic [1:0] err2;
    logic [1:0] vec2;
`ifdef XNOR_SEQ_CAPTURE_EN
    logic [3:0] cap1, cap2;
`endif

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    // The gate under test is a truth table indexed by {a,b}.
    assign y1 = resp[{a1, b1}];
    assign y2 = resp[{a2, b2}];

    xnor_test_sequencer #(.DWELL_CYCLES(4), .ERR_W(3)) dut1 (
        .clk(clk), .rst(rst), .start(start), .y_in(y1),
        .a_out(a1), .b_out(b1), .busy(busy1), .done(done1), .pass(pass1),
        .err_count(err1), .vec_idx(vec1)
`ifdef XNOR_SEQ_CAPTURE_EN
        , .capture(cap1)
`endif
    );

    xnor_test_sequencer #(.DWELL_CYCLES(1), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .start(start), .y_in(y2),
        .a_out(a2), .b_out(b2), .busy(busy2), .done(done2), .pass(pass2),
        .err_count(err2), .vec_idx(vec2)
`ifdef XNOR_SEQ_CAPTURE_EN
        , .capture(cap2)
`endif
    );

    logic [9:0] got1, got2;
    assign got1 = {busy1, done1, pass1, a1, b1, vec1, err1};
    assign got2 = {busy2, done2, pass2, a2, b2, vec2, 1'b0, err2};

    // Reference model: mk = cycles since the accepting edge (0 = idle).
    int         dw   [2] = '{4, 1};
    int         emax [2] = '{7, 3};
    int         mk   [2] = '{0, 0};
    int         merr [2] = '{0, 0};
    logic       mpass[2] = '{1'b0, 1'b0};
    logic [3:0] mcap [2] = '{4'b0, 4'b0};

    always @(posedge clk or posedge rst) begin
        for (int i = 0; i < 2; i++) begin
            int k;
            int e;
            int v;
            logic p;
            logic [3:0] c;
            k = mk[i]; e = merr[i]; p = mpass[i]; c = mcap[i];
            if (rst) begin
                k = 0; e = 0; p = 1'b0; c = 4'b0;
            end else if (k == 0) begin
                if (start) begin
                    k = 1; e = 0; p = 1'b0; c = 4'b0;
                end
            end else if (k <= 4 * dw[i]) begin
                if (k % dw[i] == 0) begin
                    v = (k - 1) / dw[i];
                    c[v] = resp[v];
                    if (resp[v] != idealTab[v] && e < emax[i]) e = e + 1;
                    if (v == 3) p = (e == 0);
                end
                k = k + 1;
            end else begin
                k = 0;
            end
            mk[i]    <= k;
            merr[i]  <= e;
            mpass[i] <= p;
            mcap[i]  <= c;
        end
    end

    function automatic logic [9:0] expOut(input int i);
        int k;
        logic bz, dn;
        logic [1:0] v;
        k  = mk[i];
        bz = (k >= 1) && (k <= 4 * dw[i]);
        dn = (k == 4 * dw[i] + 1);
        v  = bz ? 2'((k - 1) / dw[i]) : 2'd0;
        return {bz, dn, mpass[i], v[1], v[0], v, 3'(merr[i])};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
        end
    endtask

    // Per-cycle comparison of both instances against the model.
    always @(negedge clk) begin
        if (!rst) begin
            checkOutput("outs1", 32'(got1), 32'(expOut(0)));
            checkOutput("outs2", 32'(got2), 32'(expOut(1)));
`ifdef XNOR_SEQ_CAPTURE_EN
            checkOutput("cap1", 32'(cap1), 32'(mcap[0]));
            checkOutput("cap2", 32'(cap2), 32'(mcap[1]));
`endif
        end
    end

    int vecSeq[$];

    // One start pulse; reports the cycle (after the accepting edge) done was seen.
    task automatic applyStimulus(input logic [3:0] r, output int d1, output int d2);
        int n;
        n = 0; d1 = 0; d2 = 0;
        vecSeq.delete();
        resp = r;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        while ((d1 == 0 || d2 == 0) && n < 100) begin
            @(negedge clk);
            n++;
            if (busy2) vecSeq.push_back(int'(vec2));
            if (done1 && d1 == 0) d1 = n;
            if (done2 && d2 == 0) d2 = n;
        end
        checkOutput("doneSeen", {30'b0, d1 != 0, d2 != 0}, 32'd3);
        @(posedge clk);
        #1;
    endtask

    task automatic waitIdle();
        int n;
        n = 0;
        @(negedge clk);
        while ((busy1 || done1 || busy2 || done2) && n < 60) begin
            @(negedge clk);
            n++;
        end
        checkOutput("idleReached", {31'b0, busy1 | done1 | busy2 | done2}, 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int d1, d2, busyLen, gap, n;
        logic seenDone;
        logic [7:0] seqPacked;
        logic [3:0] rr;

        repeat (2) @(posedge clk);
        #1;
        checkOutput("resetOuts1", 32'(got1), 32'd0);
        checkOutput("resetOuts2", 32'(got2), 32'd0);
        rst = 1'b0;

        $display("[TB] ideal gate run");
        applyStimulus(4'b1001, d1, d2);
        checkOutput("idealDone1Cycle", d1, 17);
        checkOutput("idealDone2Cycle", d2, 5);
        checkOutput("idealPass1", 32'(pass1), 1);
        checkOutput("idealErr1", 32'(err1), 0);
        checkOutput("idealPass2", 32'(pass2), 1);
        seqPacked = (vecSeq.size() == 4) ?
            {vecSeq[0][1:0], vecSeq[1][1:0], vecSeq[2][1:0], vecSeq[3][1:0]} : 8'hff;
        checkOutput("dwell1VecSeq", 32'(seqPacked), 32'h1b);
`ifdef XNOR_SEQ_CAPTURE_EN
        checkOutput("idealCapture", 32'(cap1), 32'h9);
`endif

        $display("[TB] stuck-at-0 gate run");
        applyStimulus(4'b0000, d1, d2);
        checkOutput("stuckErr1", 32'(err1), 2);
        checkOutput("stuckPass1", 32'(pass1), 0);
        checkOutput("stuckErr2", 32'(err2), 2);
`ifdef XNOR_SEQ_CAPTURE_EN
        checkOutput("stuckCapture", 32'(cap1), 0);
`endif

        $display("[TB] XOR gate run");
        applyStimulus(4'b0110, d1, d2);
        checkOutput("xorErr1", 32'(err1), 4);
        checkOutput("xorPass1", 32'(pass1), 0);
        checkOutput("xorErr2Sat", 32'(err2), 3);

        $display("[TB] start held high");
        resp = 4'b1001;
        start = 1'b1;
        busyLen = 0; gap = 0; n = 0; seenDone = 1'b0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (!seenDone) begin
                if (busy1) busyLen++;
                if (done1) seenDone = 1'b1;
            end else begin
                gap++;
                if (busy1) break;
            end
        end
        checkOutput("heldBusyLen", busyLen, 16);
        checkOutput("heldRestartGap", gap, 2);
        start = 1'b0;
        waitIdle();

        $display("[TB] reset mid-run");
        resp = 4'b1001;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        repeat (6) @(negedge clk);
        checkOutput("preResetBusy", 32'(busy1), 1);
        #2 rst = 1'b1;
        #1;
        checkOutput("asyncReset1", 32'(got1), 0);
        checkOutput("asyncReset2", 32'(got2), 0);
`ifdef XNOR_SEQ_CAPTURE_EN
        checkOutput("asyncResetCap", 32'(cap1), 0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        applyStimulus(4'b1001, d1, d2);
        checkOutput("postResetDone", d1, 17);
        checkOutput("postResetPass", 32'(pass1), 1);

        $display("[TB] random gate tables");
        repeat (8) begin
            rr = 4'($urandom_range(0, 15));
            applyStimulus(rr, d1, d2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
